// File: rtl/mem_arbiter_rr.sv
// N-port arbiter between the L1 caches and the single physical-memory port.
// Round-robin or fixed-priority (highest index wins) grant policy, registered
// grant id, combinational request/response routing for the granted port.
module mem_arbiter_rr #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int RR_MODE    = 1,
  parameter int GID_W      = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             port_read,
  input  logic [NUM_PORTS-1:0]             port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata,
  output logic [NUM_PORTS-1:0]             port_resp,
  output logic [DATA_WIDTH-1:0]            port_rdata,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [ADDR_WIDTH-1:0]            pmem_address,
  output logic [DATA_WIDTH-1:0]            pmem_wdata,
  input  logic                             pmem_resp,
  input  logic [DATA_WIDTH-1:0]            pmem_rdata,
  output logic                             grant_valid,
  output logic [GID_W-1:0]                 grant_id
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state, state_nxt;
  logic [GID_W-1:0]       gid_nxt;
  logic [GID_W-1:0]       rr_ptr, rr_nxt;
  logic [GID_W-1:0]       ptr_after;
  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS-1:0]   sel_oh;
  logic [NUM_PORTS-1:0]   req_masked;
  logic                   req_g;

  // Winner over req. The request vector is rotated so that index 0 of the
  // rotated view is the RR start point; in fixed mode the rotation is zero
  // and the highest requesting index wins instead.
  function automatic logic [GID_W-1:0] arb_pick(input logic [NUM_PORTS-1:0] r,
                                                input logic [GID_W-1:0]     start);
    logic [GID_W-1:0]     rot;
    logic [NUM_PORTS-1:0] rr_view;
    logic [GID_W-1:0]     w;
    rot     = (RR_MODE != 0) ? start : '0;
    rr_view = NUM_PORTS'({r, r} >> rot);
    w       = '0;
    if (RR_MODE != 0) begin
      for (int unsigned i = NUM_PORTS; i > 0; i--) begin
        if (rr_view[i-1]) w = GID_W'((32'(rot) + i - 1) % NUM_PORTS);
      end
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (rr_view[i]) w = GID_W'(i);
      end
    end
    return w;
  endfunction

  assign req         = port_read | port_write;
  assign grant_valid = (state == BUSY);
  assign port_rdata  = pmem_rdata;
  assign ptr_after   = GID_W'((32'(grant_id) + 1) % NUM_PORTS);

  // One-hot decode of the current grant, used for masking and muxing.
  always_comb begin
    sel_oh = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      sel_oh[i] = (grant_id == GID_W'(i));
    end
  end

  assign req_masked = req & ~sel_oh;
  assign req_g      = |(req & sel_oh);

  // Next-state: grant in IDLE, back-to-back handoff on response, abort on strobe drop.
  always_comb begin
    state_nxt = state;
    gid_nxt   = grant_id;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (|req) begin
          gid_nxt   = arb_pick(req, rr_ptr);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (pmem_resp) begin
          // Re-arbitration starts from the advanced pointer so the finishing
          // port goes to the back of the queue immediately.
          if (RR_MODE != 0) rr_nxt = ptr_after;
          if (|req_masked) begin
            gid_nxt = arb_pick(req_masked, ptr_after);
          end else begin
            state_nxt = IDLE;
          end
        end else if (!req_g) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= gid_nxt;
      rr_ptr   <= rr_nxt;
    end
  end

  // Route the granted port to pmem and pmem_resp back; write wins over read.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    port_resp    = '0;
    if (state == BUSY) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (sel_oh[i]) begin
          pmem_write   = port_write[i];
          pmem_read    = port_read[i] & ~port_write[i];
          pmem_address = port_address[i*ADDR_WIDTH +: ADDR_WIDTH];
          pmem_wdata   = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
          port_resp[i] = pmem_resp;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a 4-port round-robin instance driven
// from a per-cycle vector table, and a 2-port fixed-priority instance
// driven by hand-written sequences.
module tb_mem_arbiter_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- 4-port round-robin instance ----------------
  logic         a_rst_n;
  logic [3:0]   a_rd, a_wr, a_presp_o;
  logic [63:0]  a_addr;
  logic [511:0] a_wdata;
  logic [127:0] a_rdata_o, a_pwdata, a_prdata;
  logic         a_pread, a_pwrite, a_presp, a_gv;
  logic [15:0]  a_paddr;
  logic [1:0]   a_gid;

  mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(128), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(a_rst_n),
    .port_read(a_rd), .port_write(a_wr),
    .port_address(a_addr), .port_wdata(a_wdata),
    .port_resp(a_presp_o), .port_rdata(a_rdata_o),
    .pmem_read(a_pread), .pmem_write(a_pwrite),
    .pmem_address(a_paddr), .pmem_wdata(a_pwdata),
    .pmem_resp(a_presp), .pmem_rdata(a_prdata),
    .grant_valid(a_gv), .grant_id(a_gid)
  );

  // ---------------- 2-port fixed-priority instance ----------------
  logic         f_rst_n;
  logic [1:0]   f_rd, f_wr, f_presp_o;
  logic [31:0]  f_addr;
  logic [255:0] f_wdata;
  logic [127:0] f_rdata_o, f_pwdata, f_prdata;
  logic         f_pread, f_pwrite, f_presp, f_gv;
  logic [15:0]  f_paddr;
  logic         f_gid;

  mem_arbiter_rr #(.NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(128), .RR_MODE(0)) u_fp (
    .clk(clk), .rst_n(f_rst_n),
    .port_read(f_rd), .port_write(f_wr),
    .port_address(f_addr), .port_wdata(f_wdata),
    .port_resp(f_presp_o), .port_rdata(f_rdata_o),
    .pmem_read(f_pread), .pmem_write(f_pwrite),
    .pmem_address(f_paddr), .pmem_wdata(f_pwdata),
    .pmem_resp(f_presp), .pmem_rdata(f_prdata),
    .grant_valid(f_gv), .grant_id(f_gid)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] addr_of(input int k);
    return 16'h1000 + 16'(k) * 16'h0101;
  endfunction

  function automatic logic [127:0] wdata_of(input int k);
    return {4{32'hA000_0000 + 32'(k)}};
  endfunction

  typedef struct {
    logic       rst_n;
    logic [3:0] rd;
    logic [3:0] wr;
    logic       resp;
    logic       gv;
    logic [1:0] gid;
    logic       cg;     // compare grant_id on this row
    logic       prd;
    logic       pwr;
    logic [3:0] presp;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] rd, input logic [3:0] wr,
                              input logic rs, input logic gv, input logic [1:0] gid,
                              input logic cg, input logic prd, input logic pwr,
                              input logic [3:0] presp);
    vec_t v;
    v.rst_n = r; v.rd = rd; v.wr = wr; v.resp = rs; v.gv = gv; v.gid = gid;
    v.cg = cg; v.prd = prd; v.pwr = pwr; v.presp = presp;
    return v;
  endfunction

  vec_t tv[34];

  initial begin
    logic [15:0]  exp_addr;
    logic [127:0] exp_wd;
    logic [127:0] mux_wd;

    // Row fields: rst_n, rd, wr, resp | gv, gid, cmp_gid, pmem_read, pmem_write, port_resp
    tv[0]  = mk(0, 4'b0000, 4'b0000, 0,  0, 0, 1, 0, 0, 4'b0000); // reset state
    tv[1]  = mk(1, 4'b1111, 4'b0000, 0,  0, 0, 1, 0, 0, 4'b0000); // all request, IDLE
    tv[2]  = mk(1, 4'b1111, 4'b0000, 0,  1, 0, 1, 1, 0, 4'b0000); // 1-cycle latency
    tv[3]  = mk(1, 4'b1111, 4'b0000, 0,  1, 0, 1, 1, 0, 4'b0000);
    tv[4]  = mk(1, 4'b1111, 4'b0000, 1,  1, 0, 1, 1, 0, 4'b0001);
    tv[5]  = mk(1, 4'b1111, 4'b0000, 0,  1, 1, 1, 1, 0, 4'b0000); // handoff, no gap
    tv[6]  = mk(1, 4'b1111, 4'b0000, 0,  1, 1, 1, 1, 0, 4'b0000);
    tv[7]  = mk(1, 4'b1111, 4'b0000, 1,  1, 1, 1, 1, 0, 4'b0010);
    tv[8]  = mk(1, 4'b1111, 4'b0000, 0,  1, 2, 1, 1, 0, 4'b0000);
    tv[9]  = mk(1, 4'b1111, 4'b0000, 0,  1, 2, 1, 1, 0, 4'b0000);
    tv[10] = mk(1, 4'b1111, 4'b0000, 1,  1, 2, 1, 1, 0, 4'b0100);
    tv[11] = mk(1, 4'b1111, 4'b0000, 0,  1, 3, 1, 1, 0, 4'b0000);
    tv[12] = mk(1, 4'b1111, 4'b0000, 0,  1, 3, 1, 1, 0, 4'b0000);
    tv[13] = mk(1, 4'b1111, 4'b0000, 1,  1, 3, 1, 1, 0, 4'b1000);
    tv[14] = mk(1, 4'b1111, 4'b0000, 0,  1, 0, 1, 1, 0, 4'b0000); // wrapped back to 0
    tv[15] = mk(1, 4'b0001, 4'b0000, 1,  1, 0, 1, 1, 0, 4'b0001); // -> IDLE, ptr=1
    tv[16] = mk(1, 4'b0100, 4'b0000, 0,  0, 0, 0, 0, 0, 4'b0000);
    tv[17] = mk(1, 4'b0100, 4'b0000, 1,  1, 2, 1, 1, 0, 4'b0100); // -> IDLE, ptr=3
    tv[18] = mk(1, 4'b0110, 4'b0000, 0,  0, 0, 0, 0, 0, 4'b0000); // ptr=3: scan 3,0,1
    tv[19] = mk(1, 4'b0110, 4'b0000, 1,  1, 1, 1, 1, 0, 4'b0010); // ptr -> 2
    tv[20] = mk(1, 4'b0100, 4'b0000, 0,  1, 2, 1, 1, 0, 4'b0000);
    tv[21] = mk(1, 4'b0000, 4'b0000, 0,  1, 2, 1, 0, 0, 4'b0000); // abort
    tv[22] = mk(1, 4'b0000, 4'b0000, 0,  0, 0, 0, 0, 0, 4'b0000);
    tv[23] = mk(1, 4'b0110, 4'b0000, 0,  0, 0, 0, 0, 0, 4'b0000); // ptr still 2 -> port 2
    tv[24] = mk(1, 4'b0110, 4'b0000, 1,  1, 2, 1, 1, 0, 4'b0100);
    tv[25] = mk(1, 4'b0111, 4'b0000, 0,  1, 1, 1, 1, 0, 4'b0000); // port 0 waits
    tv[26] = mk(1, 4'b0111, 4'b0000, 1,  1, 1, 1, 1, 0, 4'b0010);
    tv[27] = mk(1, 4'b0101, 4'b0000, 1,  1, 2, 1, 1, 0, 4'b0100);
    tv[28] = mk(1, 4'b0001, 4'b0000, 1,  1, 0, 1, 1, 0, 4'b0001);
    tv[29] = mk(1, 4'b0000, 4'b0000, 0,  0, 0, 0, 0, 0, 4'b0000);
    tv[30] = mk(1, 4'b1000, 4'b1000, 0,  0, 0, 0, 0, 0, 4'b0000); // read+write on port 3
    tv[31] = mk(1, 4'b1000, 4'b1000, 0,  1, 3, 1, 0, 1, 4'b0000); // write wins
    tv[32] = mk(0, 4'b1000, 4'b1000, 1,  1, 3, 1, 0, 1, 4'b1000); // reset + resp together
    tv[33] = mk(1, 4'b0000, 4'b0000, 0,  0, 0, 1, 0, 0, 4'b0000); // grant dropped

    for (int k = 0; k < 4; k++) begin
      a_addr[k*16 +: 16]    = addr_of(k);
      a_wdata[k*128 +: 128] = wdata_of(k);
    end
    for (int k = 0; k < 2; k++) begin
      f_addr[k*16 +: 16]    = addr_of(k);
      f_wdata[k*128 +: 128] = wdata_of(k);
    end
    a_rst_n = 1'b0; a_rd = '0; a_wr = '0; a_presp = 1'b0; a_prdata = '0;
    f_rst_n = 1'b0; f_rd = '0; f_wr = '0; f_presp = 1'b0; f_prdata = '0;
    repeat (2) @(negedge clk);

    // ---------------- table-driven run on the 4-port RR instance ----------------
    for (int i = 0; i < 34; i++) begin
      a_rst_n  = tv[i].rst_n;
      a_rd     = tv[i].rd;
      a_wr     = tv[i].wr;
      a_presp  = tv[i].resp;
      a_prdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      exp_addr = tv[i].gv ? addr_of(int'(tv[i].gid)) : 16'h0;
      exp_wd   = tv[i].gv ? wdata_of(int'(tv[i].gid)) : 128'h0;
      chk($sformatf("row%0d grant_valid", i), 128'(a_gv), 128'(tv[i].gv));
      if (tv[i].cg) chk($sformatf("row%0d grant_id", i), 128'(a_gid), 128'(tv[i].gid));
      chk($sformatf("row%0d pmem_read", i), 128'(a_pread), 128'(tv[i].prd));
      chk($sformatf("row%0d pmem_write", i), 128'(a_pwrite), 128'(tv[i].pwr));
      chk($sformatf("row%0d port_resp", i), 128'(a_presp_o), 128'(tv[i].presp));
      chk($sformatf("row%0d pmem_address", i), 128'(a_paddr), 128'(exp_addr));
      chk($sformatf("row%0d pmem_wdata", i), a_pwdata, exp_wd);
      chk($sformatf("row%0d port_rdata", i), a_rdata_o, a_prdata);
      @(negedge clk);
    end

    // ---------------- mux check: port 2 write, port 0 arrives mid-transaction ----------------
    mux_wd = 128'hDEAD_0001_0203_0405_0607_0809_0A0B_BEEF;
    a_addr[2*16 +: 16]    = 16'h1A40;
    a_wdata[2*128 +: 128] = mux_wd;
    a_rd = 4'b0000; a_wr = 4'b0100; a_presp = 1'b0;
    #1 chk("mux idle grant_valid", 128'(a_gv), 128'd0);
    @(negedge clk);
    a_rd = 4'b0001;
    #1;
    chk("mux grant_id", 128'(a_gid), 128'd2);
    chk("mux pmem_write", 128'(a_pwrite), 128'd1);
    chk("mux pmem_read", 128'(a_pread), 128'd0);
    chk("mux pmem_address", 128'(a_paddr), 128'h1A40);
    chk("mux pmem_wdata", a_pwdata, mux_wd);
    @(negedge clk);
    #1 chk("mux grant held", 128'(a_gid), 128'd2);
    a_presp = 1'b1;
    #1 chk("mux port_resp", 128'(a_presp_o), 128'b0100);
    @(negedge clk);
    a_wr = 4'b0000; a_presp = 1'b0;
    #1;
    chk("mux handoff grant_id", 128'(a_gid), 128'd0);
    chk("mux handoff pmem_read", 128'(a_pread), 128'd1);
    chk("mux handoff pmem_address", 128'(a_paddr), 128'(addr_of(0)));
    a_presp = 1'b1;
    @(negedge clk);
    a_rd = 4'b0000; a_presp = 1'b0;
    #1;
    chk("mux end grant_valid", 128'(a_gv), 128'd0);
    chk("mux end pmem_address", 128'(a_paddr), 128'd0);

    // ---------------- 2-port fixed priority: single request then priority ----------------
    f_rst_n = 1'b1;
    @(negedge clk);
    f_rd = 2'b01;
    #1 chk("fp c0 grant_valid", 128'(f_gv), 128'd0);
    @(negedge clk);
    #1;
    chk("fp c1 grant_id", 128'(f_gid), 128'd0);
    chk("fp c1 pmem_read", 128'(f_pread), 128'd1);
    repeat (2) @(negedge clk);
    #1 chk("fp c3 still busy", 128'(f_gv), 128'd1);
    @(negedge clk);
    f_presp = 1'b1;
    #1 chk("fp c4 port_resp", 128'(f_presp_o), 128'b01);
    @(negedge clk);
    f_presp = 1'b0; f_rd = 2'b00;
    #1;
    chk("fp c5 grant_valid", 128'(f_gv), 128'd0);
    chk("fp c5 pmem_read", 128'(f_pread), 128'd0);
    @(negedge clk);
    f_rd = 2'b11;
    #1 chk("fp both idle", 128'(f_gv), 128'd0);
    @(negedge clk);
    #1;
    chk("fp highest wins", 128'(f_gid), 128'd1);
    chk("fp highest valid", 128'(f_gv), 128'd1);
    @(negedge clk);
    f_presp = 1'b1;
    #1 chk("fp resp port1", 128'(f_presp_o), 128'b10);
    @(negedge clk);
    f_presp = 1'b0; f_rd = 2'b01;
    #1;
    chk("fp handoff grant_valid", 128'(f_gv), 128'd1);
    chk("fp handoff grant_id", 128'(f_gid), 128'd0);
    chk("fp handoff pmem_address", 128'(f_paddr), 128'(addr_of(0)));
    f_presp = 1'b1;
    @(negedge clk);
    f_presp = 1'b0; f_rd = 2'b00;
    #1 chk("fp final idle", 128'(f_gv), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
